// File: rtl/issue_dispatcher_if.sv
// Bundle of every non-clock, non-reset signal between the issue dispatcher
// and its neighbours: decoder, ROB, register file, reservation station,
// load/store buffer and the common data bus.
interface issue_dispatcher_if #(
   parameter int TAG_W = 4,
   parameter int XLEN  = 32
);
   logic             rdy;
   logic             flush;

   logic             id_valid;
   logic             id_ready;
   logic [5:0]       id_op;
   logic             id_is_mem;
   logic [XLEN-1:0]  id_pc;
   logic [XLEN-1:0]  id_imm;
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic [4:0]       id_rd;

   logic             rob_free;
   logic [TAG_W-1:0] rob_tag;
   logic             rob_alloc;

   logic [4:0]       rf_rs1;
   logic [4:0]       rf_rs2;
   logic             rf_busy1;
   logic             rf_busy2;
   logic [TAG_W-1:0] rf_tag1;
   logic [TAG_W-1:0] rf_tag2;
   logic [XLEN-1:0]  rf_val1;
   logic [XLEN-1:0]  rf_val2;

   logic             rf_ren_we;
   logic [4:0]       rf_ren_rd;
   logic [TAG_W-1:0] rf_ren_tag;

   logic             rs_full;
   logic             rs_we;
   logic             lsb_full;
   logic             lsb_we;

   logic             cdb_valid;
   logic [TAG_W-1:0] cdb_tag;
   logic [XLEN-1:0]  cdb_value;

   logic [5:0]       ds_op;
   logic [XLEN-1:0]  ds_pc;
   logic [XLEN-1:0]  ds_imm;
   logic [XLEN-1:0]  ds_v1;
   logic [XLEN-1:0]  ds_v2;
   logic [TAG_W-1:0] ds_q1;
   logic [TAG_W-1:0] ds_q2;
   logic             ds_b1;
   logic             ds_b2;
   logic [4:0]       ds_rd;
   logic [TAG_W-1:0] ds_tag;

   // Environment side: drives decoder, ROB, regfile, target and CDB inputs.
   modport master (
      output rdy, flush,
      output id_valid, id_op, id_is_mem, id_pc, id_imm, id_rs1, id_rs2, id_rd,
      output rob_free, rob_tag,
      output rf_busy1, rf_busy2, rf_tag1, rf_tag2, rf_val1, rf_val2,
      output rs_full, lsb_full,
      output cdb_valid, cdb_tag, cdb_value,
      input  id_ready, rob_alloc, rf_rs1, rf_rs2,
      input  rf_ren_we, rf_ren_rd, rf_ren_tag,
      input  rs_we, lsb_we,
      input  ds_op, ds_pc, ds_imm, ds_v1, ds_v2, ds_q1, ds_q2,
      input  ds_b1, ds_b2, ds_rd, ds_tag
   );

   // Dispatcher side.
   modport slave (
      input  rdy, flush,
      input  id_valid, id_op, id_is_mem, id_pc, id_imm, id_rs1, id_rs2, id_rd,
      input  rob_free, rob_tag,
      input  rf_busy1, rf_busy2, rf_tag1, rf_tag2, rf_val1, rf_val2,
      input  rs_full, lsb_full,
      input  cdb_valid, cdb_tag, cdb_value,
      output id_ready, rob_alloc, rf_rs1, rf_rs2,
      output rf_ren_we, rf_ren_rd, rf_ren_tag,
      output rs_we, lsb_we,
      output ds_op, ds_pc, ds_imm, ds_v1, ds_v2, ds_q1, ds_q2,
      output ds_b1, ds_b2, ds_rd, ds_tag
   );
endinterface

// File: rtl/issue_dispatcher.sv
// In-order issue dispatcher: buffers decoded instructions in a small FIFO,
// and once per cycle renames the head, resolves its source operands against
// the register file and the CDB, and writes it to the reservation station
// (ALU ops) or the load/store buffer (memory ops) one cycle later.
module issue_dispatcher #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4,
   parameter int XLEN  = 32
) (
   input logic              clk,
   input logic              rst,
   issue_dispatcher_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [XLEN-1:0]  v;
      logic [TAG_W-1:0] q;
      logic             b;
   } operand_t;

   logic [5:0]       q_op     [DEPTH];
   logic             q_is_mem [DEPTH];
   logic [XLEN-1:0]  q_pc     [DEPTH];
   logic [XLEN-1:0]  q_imm    [DEPTH];
   logic [4:0]       q_rs1    [DEPTH];
   logic [4:0]       q_rs2    [DEPTH];
   logic [4:0]       q_rd     [DEPTH];

   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;

   logic             enq;
   logic             fire;
   logic             head_is_mem;
   logic [4:0]       head_rd;
   operand_t         opnd1;
   operand_t         opnd2;

   // Operand priority: x0 is a hard zero, then a ready regfile value, then a
   // same-cycle CDB broadcast of the awaited tag, otherwise wait on the tag.
   function automatic operand_t resolve(
      input logic [4:0]       idx,
      input logic             busy,
      input logic [TAG_W-1:0] tag,
      input logic [XLEN-1:0]  val,
      input logic             cdb_valid,
      input logic [TAG_W-1:0] cdb_tag,
      input logic [XLEN-1:0]  cdb_value
   );
      operand_t r;
      r = '0;
      if (idx == 5'd0) begin
         r = '0;
      end else if (!busy) begin
         r.v = val;
      end else if (cdb_valid && (cdb_tag == tag)) begin
         r.v = cdb_value;
      end else begin
         r.q = tag;
         r.b = 1'b1;
      end
      return r;
   endfunction

   assign head_is_mem = q_is_mem[head];
   assign head_rd     = q_rd[head];

   assign bus.id_ready = (count < CNT_W'(DEPTH));
   assign enq  = bus.rdy && bus.id_valid && bus.id_ready && !bus.flush;
   assign fire = bus.rdy && !bus.flush && (count != '0) && bus.rob_free &&
                 (head_is_mem ? !bus.lsb_full : !bus.rs_full);

   assign bus.rf_rs1     = q_rs1[head];
   assign bus.rf_rs2     = q_rs2[head];
   assign bus.rob_alloc  = fire;
   assign bus.rf_ren_we  = fire && (head_rd != 5'd0);
   assign bus.rf_ren_rd  = head_rd;
   assign bus.rf_ren_tag = bus.rob_tag;

   // Resolve both head operands every cycle; only captured on fire.
   always_comb begin
      opnd1 = resolve(q_rs1[head], bus.rf_busy1, bus.rf_tag1, bus.rf_val1,
                      bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
      opnd2 = resolve(q_rs2[head], bus.rf_busy2, bus.rf_tag2, bus.rf_val2,
                      bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
   end

   // Queue payload storage; contents are don't-care outside head..tail.
   always_ff @(posedge clk) begin
      if (enq) begin
         q_op[tail]     <= bus.id_op;
         q_is_mem[tail] <= bus.id_is_mem;
         q_pc[tail]     <= bus.id_pc;
         q_imm[tail]    <= bus.id_imm;
         q_rs1[tail]    <= bus.id_rs1;
         q_rs2[tail]    <= bus.id_rs2;
         q_rd[tail]     <= bus.id_rd;
      end
   end

   // Pointers and occupancy; flush empties the queue and beats enq/fire.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (bus.rdy && bus.flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (enq)  tail <= tail + PTR_W'(1);
         if (fire) head <= head + PTR_W'(1);
         case ({enq, fire})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Target write strobes follow fire by one cycle and drop otherwise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.rs_we  <= 1'b0;
         bus.lsb_we <= 1'b0;
      end else begin
         bus.rs_we  <= fire && !head_is_mem;
         bus.lsb_we <= fire && head_is_mem;
      end
   end

   // Dispatch bus captures the head and its resolved operands on fire.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.ds_op  <= '0;
         bus.ds_pc  <= '0;
         bus.ds_imm <= '0;
         bus.ds_v1  <= '0;
         bus.ds_v2  <= '0;
         bus.ds_q1  <= '0;
         bus.ds_q2  <= '0;
         bus.ds_b1  <= 1'b0;
         bus.ds_b2  <= 1'b0;
         bus.ds_rd  <= '0;
         bus.ds_tag <= '0;
      end else if (fire) begin
         bus.ds_op  <= q_op[head];
         bus.ds_pc  <= q_pc[head];
         bus.ds_imm <= q_imm[head];
         bus.ds_v1  <= opnd1.v;
         bus.ds_v2  <= opnd2.v;
         bus.ds_q1  <= opnd1.q;
         bus.ds_q2  <= opnd2.q;
         bus.ds_b1  <= opnd1.b;
         bus.ds_b2  <= opnd2.b;
         bus.ds_rd  <= head_rd;
         bus.ds_tag <= bus.rob_tag;
      end
   end
endmodule

// File: tb/tb_issue_dispatcher.sv
// Directed bench for issue_dispatcher: a table of single-instruction dispatch
// vectors plus hand-written sequences for backpressure, ROB stall, flush,
// global-enable freeze and mid-operation reset.
module tb_issue_dispatcher;
   logic clk;
   logic rst;
   int   compared;
   int   mismatched;

   issue_dispatcher_if #(.TAG_W(4), .XLEN(32)) bus ();

   issue_dispatcher #(.DEPTH(4), .TAG_W(4), .XLEN(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      string       name;
      logic [5:0]  op;
      logic        is_mem;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [3:0]  rob_tag;
      logic        busy1;
      logic [3:0]  tag1;
      logic [31:0] val1;
      logic        busy2;
      logic [3:0]  tag2;
      logic [31:0] val2;
      logic        cdb_valid;
      logic [3:0]  cdb_tag;
      logic [31:0] cdb_value;
      logic        exp_ren;
      logic        exp_b1;
      logic [31:0] exp_v1;
      logic [3:0]  exp_q1;
      logic        exp_b2;
      logic [31:0] exp_v2;
      logic [3:0]  exp_q2;
   } vec_t;

   vec_t vecs[5];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value with its expected value.
   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs();
      bus.rdy       = 1'b1;
      bus.flush     = 1'b0;
      bus.id_valid  = 1'b0;
      bus.id_op     = '0;
      bus.id_is_mem = 1'b0;
      bus.id_pc     = '0;
      bus.id_imm    = '0;
      bus.id_rs1    = '0;
      bus.id_rs2    = '0;
      bus.id_rd     = '0;
      bus.rob_free  = 1'b1;
      bus.rob_tag   = '0;
      bus.rf_busy1  = 1'b0;
      bus.rf_busy2  = 1'b0;
      bus.rf_tag1   = '0;
      bus.rf_tag2   = '0;
      bus.rf_val1   = '0;
      bus.rf_val2   = '0;
      bus.rs_full   = 1'b0;
      bus.lsb_full  = 1'b0;
      bus.cdb_valid = 1'b0;
      bus.cdb_tag   = '0;
      bus.cdb_value = '0;
   endtask

   task automatic enqueue(input logic [5:0] op, input logic is_mem,
                          input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd);
      bus.id_valid  = 1'b1;
      bus.id_op     = op;
      bus.id_is_mem = is_mem;
      bus.id_pc     = 32'h0000_2000;
      bus.id_imm    = 32'h0000_0010;
      bus.id_rs1    = rs1;
      bus.id_rs2    = rs2;
      bus.id_rd     = rd;
   endtask

   // Drive the fire-cycle regfile, CDB and ROB inputs of one vector.
   task automatic applyStimulus(input vec_t v);
      bus.id_valid  = 1'b0;
      bus.rob_tag   = v.rob_tag;
      bus.rf_busy1  = v.busy1;
      bus.rf_tag1   = v.tag1;
      bus.rf_val1   = v.val1;
      bus.rf_busy2  = v.busy2;
      bus.rf_tag2   = v.tag2;
      bus.rf_val2   = v.val2;
      bus.cdb_valid = v.cdb_valid;
      bus.cdb_tag   = v.cdb_tag;
      bus.cdb_value = v.cdb_value;
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;

      //        name        op     mem  pc            imm           rs1 rs2 rd  rtag b1 t1 v1            b2 t2 v2            cdbv ct cdbval        ren b1 v1            q1 b2 v2            q2
      vecs[0] = '{"add",    6'h01, 0, 32'h0000_0100, 32'h0000_0004, 1,  2,  3,  2,   0, 0, 32'd5,        1, 7, 32'hDEAD_0000, 0, 0, 32'h0,        1,  0, 32'd5,        0, 1, 32'h0,        7};
      vecs[1] = '{"cdb",    6'h02, 0, 32'h0000_0104, 32'h0000_0008, 4,  5,  6,  5,   1, 7, 32'h0,        1, 3, 32'h0,        1, 7, 32'h0000_00AB, 1,  0, 32'h0000_00AB, 0, 1, 32'h0,        3};
      vecs[2] = '{"x0",     6'h03, 0, 32'h0000_0108, 32'h0000_000C, 0,  7,  0,  9,   1, 9, 32'h55,       0, 0, 32'h1234,     0, 0, 32'h0,        0,  0, 32'h0,        0, 0, 32'h1234,     0};
      vecs[3] = '{"load",   6'h10, 1, 32'h0000_010C, 32'hFFFF_FFF0, 8,  0,  9,  15,  0, 0, 32'h1000,     1, 2, 32'h7777,     0, 0, 32'h0,        1,  0, 32'h1000,     0, 0, 32'h0,        0};
      vecs[4] = '{"rfwins", 6'h04, 0, 32'h0000_0110, 32'h0000_0001, 10, 11, 31, 0,   0, 4, 32'h77,       1, 4, 32'h0,        1, 4, 32'h99,       1,  0, 32'h77,       0, 0, 32'h99,       0};

      // Reset state with rst held low.
      idleInputs();
      rst = 1'b0;
      #3;
      checkOutput("reset id_ready", bus.id_ready, 1);
      checkOutput("reset rob_alloc", bus.rob_alloc, 0);
      checkOutput("reset rf_ren_we", bus.rf_ren_we, 0);
      checkOutput("reset rs_we", bus.rs_we, 0);
      checkOutput("reset lsb_we", bus.lsb_we, 0);
      checkOutput("reset ds_tag", bus.ds_tag, 0);
      checkOutput("reset ds_v1", bus.ds_v1, 0);
      step();
      step();
      rst = 1'b1;
      step();

      // Single-instruction dispatch vectors.
      for (int i = 0; i < 5; i++) begin
         enqueue(vecs[i].op, vecs[i].is_mem, vecs[i].rs1, vecs[i].rs2, vecs[i].rd);
         bus.id_pc  = vecs[i].pc;
         bus.id_imm = vecs[i].imm;
         step();
         applyStimulus(vecs[i]);
         #1;
         checkOutput({vecs[i].name, " rf_rs1"}, bus.rf_rs1, vecs[i].rs1);
         checkOutput({vecs[i].name, " rf_rs2"}, bus.rf_rs2, vecs[i].rs2);
         checkOutput({vecs[i].name, " rob_alloc"}, bus.rob_alloc, 1);
         checkOutput({vecs[i].name, " rf_ren_we"}, bus.rf_ren_we, vecs[i].exp_ren);
         if (vecs[i].exp_ren) begin
            checkOutput({vecs[i].name, " rf_ren_rd"}, bus.rf_ren_rd, vecs[i].rd);
            checkOutput({vecs[i].name, " rf_ren_tag"}, bus.rf_ren_tag, vecs[i].rob_tag);
         end
         step();
         idleInputs();
         checkOutput({vecs[i].name, " rs_we"}, bus.rs_we, !vecs[i].is_mem);
         checkOutput({vecs[i].name, " lsb_we"}, bus.lsb_we, vecs[i].is_mem);
         checkOutput({vecs[i].name, " ds_op"}, bus.ds_op, vecs[i].op);
         checkOutput({vecs[i].name, " ds_pc"}, bus.ds_pc, vecs[i].pc);
         checkOutput({vecs[i].name, " ds_imm"}, bus.ds_imm, vecs[i].imm);
         checkOutput({vecs[i].name, " ds_rd"}, bus.ds_rd, vecs[i].rd);
         checkOutput({vecs[i].name, " ds_tag"}, bus.ds_tag, vecs[i].rob_tag);
         checkOutput({vecs[i].name, " ds_b1"}, bus.ds_b1, vecs[i].exp_b1);
         checkOutput({vecs[i].name, " ds_b2"}, bus.ds_b2, vecs[i].exp_b2);
         if (vecs[i].exp_b1) checkOutput({vecs[i].name, " ds_q1"}, bus.ds_q1, vecs[i].exp_q1);
         else                checkOutput({vecs[i].name, " ds_v1"}, bus.ds_v1, vecs[i].exp_v1);
         if (vecs[i].exp_b2) checkOutput({vecs[i].name, " ds_q2"}, bus.ds_q2, vecs[i].exp_q2);
         else                checkOutput({vecs[i].name, " ds_v2"}, bus.ds_v2, vecs[i].exp_v2);
         step();
         checkOutput({vecs[i].name, " rs_we drop"}, bus.rs_we, 0);
         checkOutput({vecs[i].name, " lsb_we drop"}, bus.lsb_we, 0);
      end

      // LSB backpressure: fill the queue with loads, then drain in order.
      bus.lsb_full = 1'b1;
      for (int k = 0; k < 4; k++) begin
         enqueue(6'h11, 1'b1, 5'd0, 5'd0, 5'(k + 1));
         #1;
         checkOutput("lsbfull rob_alloc", bus.rob_alloc, 0);
         step();
         checkOutput("lsbfull lsb_we", bus.lsb_we, 0);
      end
      bus.id_valid = 1'b0;
      checkOutput("lsbfull id_ready", bus.id_ready, 0);
      step();
      checkOutput("lsbfull held lsb_we", bus.lsb_we, 0);
      bus.lsb_full = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bus.rob_tag = 4'(k + 8);
         #1;
         checkOutput("drain rob_alloc", bus.rob_alloc, 1);
         step();
         checkOutput("drain lsb_we", bus.lsb_we, 1);
         checkOutput("drain rs_we", bus.rs_we, 0);
         checkOutput("drain ds_rd", bus.ds_rd, k + 1);
         checkOutput("drain ds_tag", bus.ds_tag, k + 8);
         checkOutput("drain id_ready", bus.id_ready, 1);
      end
      step();
      checkOutput("drain lsb_we drop", bus.lsb_we, 0);

      // ROB stall with two queued, then flush (with a competing enqueue).
      idleInputs();
      bus.rob_free = 1'b0;
      enqueue(6'h05, 1'b0, 5'd0, 5'd0, 5'd5);
      step();
      enqueue(6'h06, 1'b0, 5'd0, 5'd0, 5'd6);
      step();
      bus.id_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         checkOutput("robstall rob_alloc", bus.rob_alloc, 0);
         checkOutput("robstall rf_ren_we", bus.rf_ren_we, 0);
         step();
         checkOutput("robstall rs_we", bus.rs_we, 0);
         checkOutput("robstall count", dut.count, 2);
      end
      bus.flush = 1'b1;
      bus.rob_free = 1'b1;
      enqueue(6'h07, 1'b0, 5'd0, 5'd0, 5'd7);
      #1;
      checkOutput("flush rob_alloc", bus.rob_alloc, 0);
      step();
      bus.flush = 1'b0;
      bus.id_valid = 1'b0;
      checkOutput("flush count", dut.count, 0);
      checkOutput("flush id_ready", bus.id_ready, 1);
      checkOutput("flush rs_we", bus.rs_we, 0);
      #1;
      checkOutput("postflush rob_alloc", bus.rob_alloc, 0);
      step();
      checkOutput("postflush rs_we", bus.rs_we, 0);

      // Global enable low freezes queue and dispatch bus.
      enqueue(6'h22, 1'b0, 5'd0, 5'd0, 5'd12);
      step();
      bus.rdy = 1'b0;
      enqueue(6'h23, 1'b0, 5'd0, 5'd0, 5'd13);
      for (int k = 0; k < 2; k++) begin
         #1;
         checkOutput("rdylow rob_alloc", bus.rob_alloc, 0);
         step();
         checkOutput("rdylow rs_we", bus.rs_we, 0);
         checkOutput("rdylow ds_rd held", bus.ds_rd, 4);
         checkOutput("rdylow ds_op held", bus.ds_op, 6'h11);
         checkOutput("rdylow count", dut.count, 1);
      end
      bus.rdy = 1'b1;
      bus.id_valid = 1'b0;
      bus.rob_tag = 4'd6;
      step();
      checkOutput("rdyhigh rs_we", bus.rs_we, 1);
      checkOutput("rdyhigh ds_rd", bus.ds_rd, 12);
      checkOutput("rdyhigh ds_op", bus.ds_op, 6'h22);
      checkOutput("rdyhigh ds_tag", bus.ds_tag, 6);
      step();
      checkOutput("rdyhigh rs_we drop", bus.rs_we, 0);

      // Asynchronous reset with three queued and rs_we high.
      idleInputs();
      bus.rob_free = 1'b0;
      for (int k = 0; k < 4; k++) begin
         enqueue(6'h30, 1'b0, 5'd0, 5'd0, 5'(k + 20));
         step();
      end
      bus.id_valid = 1'b0;
      bus.rob_free = 1'b1;
      step();
      bus.rob_free = 1'b0;
      checkOutput("prereset rs_we", bus.rs_we, 1);
      checkOutput("prereset count", dut.count, 3);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("asyncrst rs_we", bus.rs_we, 0);
      checkOutput("asyncrst count", dut.count, 0);
      checkOutput("asyncrst id_ready", bus.id_ready, 1);
      checkOutput("asyncrst rob_alloc", bus.rob_alloc, 0);
      checkOutput("asyncrst ds_rd", bus.ds_rd, 0);
      step();
      rst = 1'b1;
      bus.rob_free = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         checkOutput("postrst rob_alloc", bus.rob_alloc, 0);
         step();
         checkOutput("postrst rs_we", bus.rs_we, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/issue_dispatcher.md
ISSUE_DISPATCHER -- requirements
Module: issue_dispatcher

Interface
REQ-001 SHALL have parameter DEPTH, default 4, instruction-queue entries (power of two, >=2).
REQ-002 SHALL have parameter TAG_W, default 4, ROB tag width.
REQ-003 SHALL have parameter XLEN, default 32, data/address width.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port rdy  in  1  global enable; low freezes all state.
REQ-007 SHALL have port flush  in  1  mispredict flush.
REQ-008 SHALL have ports id_valid in 1 / id_ready out 1: decoder enqueue handshake.
REQ-009 SHALL have ports id_op in 6, id_is_mem in 1, id_pc in XLEN, id_imm in XLEN, id_rs1/id_rs2/id_rd in 5 each: decoded fields.
REQ-010 SHALL have ports rob_free in 1, rob_tag in TAG_W, rob_alloc out 1: ROB slot availability, next tag, allocate strobe.
REQ-011 SHALL have ports rf_rs1/rf_rs2 out 5, rf_busy1/rf_busy2 in 1, rf_tag1/rf_tag2 in TAG_W, rf_val1/rf_val2 in XLEN: combinational regfile read.
REQ-012 SHALL have ports rf_ren_we out 1, rf_ren_rd out 5, rf_ren_tag out TAG_W: rename write.
REQ-013 SHALL have ports rs_full in 1, rs_we out 1, lsb_full in 1, lsb_we out 1: target capacity and write strobes.
REQ-014 SHALL have ports cdb_valid in 1, cdb_tag in TAG_W, cdb_value in XLEN: result broadcast.
REQ-015 SHALL have registered output bus ds_op 6, ds_pc/ds_imm XLEN, ds_v1/ds_v2 XLEN, ds_q1/ds_q2 TAG_W, ds_b1/ds_b2 1, ds_rd 5, ds_tag TAG_W.

Function
REQ-016 SHALL hold a circular FIFO of DEPTH entries, head/tail pointers log2(DEPTH) bits wrapping modulo DEPTH, count 0..DEPTH.
REQ-017 SHALL drive id_ready = (count < DEPTH) combinationally; no same-cycle full bypass.
REQ-018 SHALL enqueue at tail when rdy & id_valid & id_ready & !flush.
REQ-019 SHALL define fire = rdy & !flush & count>0 & rob_free & (head.is_mem ? !lsb_full : !rs_full).
REQ-020 SHALL drive rf_rs1/rf_rs2 from head entry at all times.
REQ-021 SHALL resolve each operand: index 0 -> value 0, busy 0; else rf_busy=0 -> rf_val; else cdb_valid & cdb_tag==rf_tag -> cdb_value, busy 0; else tag rf_tag, busy 1.
REQ-022 SHALL assert rob_alloc combinationally in the fire cycle only.
REQ-023 SHALL assert rf_ren_we combinationally on fire when head.rd != 0, with rf_ren_rd=head.rd, rf_ren_tag=rob_tag.
REQ-024 SHALL on fire register head fields, resolved operands and ds_tag=rob_tag, and pulse lsb_we (is_mem) or rs_we (else) exactly one cycle after fire.
REQ-025 SHALL dispatch at most one instruction per cycle, in program order.
REQ-026 SHALL update count by +1 enqueue-only, -1 fire-only, unchanged when both or neither.
REQ-027 SHALL on flush (rdy high) clear head, tail, count and deassert rs_we/lsb_we next cycle; flush dominates enqueue and fire.
REQ-028 SHALL while rdy low hold FIFO, pointers and ds_* outputs, with rs_we/lsb_we forced to 0 next cycle.
REQ-029 SHALL deassert rs_we/lsb_we the cycle after any non-fire cycle.

Reset
REQ-030 SHALL on rst low asynchronously clear head, tail, count, rs_we, lsb_we, and all ds_* to 0.
REQ-031 SHALL with rst low drive id_ready=1 (count 0) and rob_alloc=rf_ren_we=0.
REQ-032 SHALL drop any in-flight entries on reset mid-operation; first post-reset fire requires a fresh enqueue.

Verification
REQ-033 SHALL test: enqueue ADD rd=3 rs1=1(val 5) rs2=2(busy tag 7), rob_tag=2 -> fire same cycle, rf_ren_we rd=3 tag=2, next cycle rs_we=1, ds_v1=5, ds_b2=1, ds_q2=7, ds_tag=2.
REQ-034 SHALL test: operand busy tag 7 with cdb_valid tag 7 value 0xAB in fire cycle -> ds_b=0, ds_v=0xAB.
REQ-035 SHALL test: lsb_full=1, enqueue 4 loads (DEPTH=4) -> id_ready=0 after 4th, no lsb_we; release lsb_full -> 4 lsb_we pulses in order, id_ready=1.
REQ-036 SHALL test: rob_free=0 with 2 queued -> no rob_alloc, no strobes, count stays 2; flush -> count 0, id_ready=1.
REQ-037 SHALL test: rs1=0, rd=0 instruction -> ds_v1=0, ds_b1=0, rf_ren_we stays 0 while rs_we pulses.
REQ-038 SHALL test: rst low while 3 queued and rs_we high -> rs_we=0 and count=0 immediately, no dispatch after release.
